// File: rtl/mux8_arb_pkg.sv
// Shared sizes and state encoding for the eight-way round-robin mux arbiter.
package mux8_arb_pkg;
  localparam int N_REQ  = 8;
  localparam int SEL_W  = 3;
  localparam int HOLD_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request at or after ptr, wrapping 7->0.
module rr_pick
  import mux8_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SEL_W-1:0]   enc;

  always_comb begin
    dbl = {req, req};
    rot = dbl[ptr +: N_REQ];
    enc = '0;
    // Scan downward so the lowest set bit of the rotated vector wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) enc = SEL_W'(k);
    end
    any = |req;
    idx = enc + ptr;
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select pins of an 8:1 mux, with a hold limit
// per tenure and one dead cycle between tenures.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic             valid,
  output logic             timeout
);

  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

  arb_state_t        state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              timeout_q, timeout_d;

  logic              pick_any;
  logic [SEL_W-1:0]  pick_idx;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          sel_d   = pick_idx;
          grant_d = N_REQ'(1) << pick_idx;
          hold_d  = HOLD_W'(1);
        end
      end
      GRANT: begin
        // Voluntary release outranks hold expiry, so no timeout on a collision.
        if (!req[sel_q] || (hold_q == HOLD_LIMIT)) begin
          state_d   = IDLE;
          grant_d   = '0;
          ptr_d     = sel_q + SEL_W'(1);
          hold_d    = '0;
          timeout_d = req[sel_q];
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      grant_q   <= '0;
      sel_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant   = grant_q;
  assign sel     = sel_q;
  assign valid   = |grant_q;
  assign timeout = timeout_q;

endmodule
